// File: rtl/cnt_sched_pkg.sv
// Shared encodings for the two-requester counter command scheduler.
package cnt_sched_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_GRANT = 2'b01,
    ST_EXEC  = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    CMD_NOP  = 2'b00,
    CMD_LOAD = 2'b01,
    CMD_INC  = 2'b10,
    CMD_DEC  = 2'b11
  } cmd_t;

endpackage

// File: rtl/cnt_updown.sv
// Loadable up/down counter with wrap-around; load has priority over count enable.
module cnt_updown #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic             up,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] cnt
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= din;
    end else if (en) begin
      cnt <= up ? cnt + 1'b1 : cnt - 1'b1;
    end
  end

endmodule

// File: rtl/cnt_cmd_sched.sv
// Round-robin scheduler sharing one up/down counter between two requesters.
// state | meaning: IDLE wait for req, GRANT pulse gnt, EXEC apply cmd, DONE pulse done
module cnt_cmd_sched
  import cnt_sched_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [1:0]       cmd0,
  input  logic [WIDTH-1:0] din0,
  input  logic             req1,
  input  logic [1:0]       cmd1,
  input  logic [WIDTH-1:0] din1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [WIDTH-1:0] cnt
);

  state_t           state, next_state;
  logic             win_id, next_id;
  logic             last;
  cmd_t             cmd_q;
  logic [WIDTH-1:0] din_q;
  logic             done_id_q;
  logic             cnt_load, cnt_en, cnt_up;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    next_id    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        // on a tie the requester that did not win last time gets the slot
        if (req0 && req1) begin
          next_id = ~last;
        end else begin
          next_id = req1;
        end
        if (req0 || req1) begin
          next_state = ST_GRANT;
        end
      end
      ST_GRANT: next_state = ST_EXEC;
      ST_EXEC:  next_state = ST_DONE;
      ST_DONE:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_id    <= 1'b0;
      last      <= 1'b1;
      cmd_q     <= CMD_NOP;
      din_q     <= '0;
      done_id_q <= 1'b0;
    end else begin
      if (state == ST_IDLE && (req0 || req1)) begin
        win_id <= next_id;
        last   <= next_id;
        cmd_q  <= next_id ? cmd_t'(cmd1) : cmd_t'(cmd0);
        din_q  <= next_id ? din1 : din0;
      end
      if (state == ST_EXEC) begin
        done_id_q <= win_id;
      end
    end
  end

  assign cnt_load = (state == ST_EXEC) && (cmd_q == CMD_LOAD);
  assign cnt_en   = (state == ST_EXEC) && (cmd_q == CMD_INC || cmd_q == CMD_DEC);
  assign cnt_up   = (cmd_q == CMD_INC);

  cnt_updown #(.WIDTH(WIDTH)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .load  (cnt_load),
    .en    (cnt_en),
    .up    (cnt_up),
    .din   (din_q),
    .cnt   (cnt)
  );

  assign gnt0    = (state == ST_GRANT) && !win_id;
  assign gnt1    = (state == ST_GRANT) && win_id;
  assign busy    = (state != ST_IDLE);
  assign done    = (state == ST_DONE);
  assign done_id = done_id_q;

endmodule

// File: tb/tb_cnt_cmd_sched.sv
// Directed bench for cnt_cmd_sched; completions checked against a scoreboard queue.
module tb_cnt_cmd_sched;

  localparam logic [1:0] NOP  = 2'b00;
  localparam logic [1:0] LOAD = 2'b01;
  localparam logic [1:0] INC  = 2'b10;
  localparam logic [1:0] DEC  = 2'b11;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0, req1;
  logic [1:0] cmd0, cmd1;
  logic [7:0] din0, din1;
  logic       gnt0, gnt1, busy, done, done_id;
  logic [7:0] cnt;

  typedef struct packed {
    logic       id;
    logic [7:0] cnt;
  } exp_t;

  exp_t       sb[$];
  logic       gq[$];
  logic [7:0] model;
  int         n_checks = 0;
  int         n_pass   = 0;
  int         done_by_id[2];

  cnt_cmd_sched #(.WIDTH(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .req0    (req0),
    .cmd0    (cmd0),
    .din0    (din0),
    .req1    (req1),
    .cmd1    (cmd1),
    .din1    (din1),
    .gnt0    (gnt0),
    .gnt1    (gnt1),
    .busy    (busy),
    .done    (done),
    .done_id (done_id),
    .cnt     (cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] apply(input logic [1:0] c, input logic [7:0] d,
                                       input logic [7:0] cur);
    case (c)
      LOAD:    return d;
      INC:     return cur + 8'd1;
      DEC:     return cur - 8'd1;
      default: return cur;
    endcase
  endfunction

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    if (done) begin
      chk("sb_has_entry", (sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("done_id", done_id, e.id);
        chk("done_cnt", cnt, e.cnt);
      end
    end
  endtask

  // full transaction with nominal-latency checks; cmd/din scrambled after the latch edge
  task automatic issue(input logic id, input logic [1:0] c, input logic [7:0] d);
    model = apply(c, d, model);
    sb.push_back('{id: id, cnt: model});
    if (id) begin req1 = 1'b1; cmd1 = c; din1 = d; end
    else    begin req0 = 1'b1; cmd0 = c; din0 = d; end
    step();
    chk("gnt_latency", id ? gnt1 : gnt0, 1);
    chk("gnt_other", id ? gnt0 : gnt1, 0);
    chk("busy_grant", busy, 1);
    req0 = 1'b0; req1 = 1'b0;
    cmd0 = ~c; cmd1 = ~c; din0 = ~d; din1 = ~d;
    step();
    chk("exec_no_gnt", gnt0 | gnt1, 0);
    chk("exec_no_done", done, 0);
    step();
    chk("done_latency", done, 1);
    step();
    chk("idle_busy", busy, 0);
    chk("done_one_cycle", done, 0);
    chk("done_id_hold", done_id, id);
  endtask

  initial begin
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    cmd0 = NOP;  cmd1 = NOP;
    din0 = 8'h00; din1 = 8'h00;
    model = 8'h00;
    done_by_id[0] = 0; done_by_id[1] = 0;
    #1;
    chk("rst_cnt", cnt, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_gnt", {gnt0, gnt1}, 2'b00);
    chk("rst_done", done, 0);
    chk("rst_done_id", done_id, 0);
    #22 reset = 1'b0;

    // reset during EXEC of a LOAD drops the command
    req0 = 1'b1; cmd0 = LOAD; din0 = 8'hA5;
    step();
    chk("t1_gnt0", gnt0, 1);
    req0 = 1'b0;
    step();
    chk("t1_exec_busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    chk("t1_async_busy", busy, 0);
    chk("t1_async_cnt", cnt, 8'h00);
    chk("t1_async_done", done, 0);
    @(posedge clk);
    #2 reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t1_no_done", done, 0);
      chk("t1_cnt_zero", cnt, 8'h00);
    end

    // both requesting INC: first tie goes to 0 after reset, then alternates
    for (int k = 0; k < 4; k++) begin
      model = model + 8'd1;
      sb.push_back('{id: logic'(k % 2), cnt: model});
    end
    req0 = 1'b1; req1 = 1'b1; cmd0 = INC; cmd1 = INC;
    for (int i = 0; i < 16; i++) begin
      step();
      if (gnt0) gq.push_back(1'b0);
      if (gnt1) gq.push_back(1'b1);
      if (done) done_by_id[done_id]++;
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("t4_gnt_count", gq.size(), 4);
    for (int k = 0; k < gq.size() && k < 4; k++) chk("t4_gnt_order", gq[k], k % 2);
    chk("t4_cnt", cnt, 8'h04);
    chk("t4_done0", done_by_id[0], 2);
    chk("t4_done1", done_by_id[1], 2);
    chk("t4_sb_drained", sb.size(), 0);
    step();
    chk("t4_idle", busy, 0);

    // LOAD latency
    issue(1'b0, LOAD, 8'h3C);
    chk("t2_cnt", cnt, 8'h3C);

    // wrap both ways
    issue(1'b0, LOAD, 8'hFF);
    issue(1'b1, INC, 8'h00);
    chk("t3_wrap_up", cnt, 8'h00);
    issue(1'b0, DEC, 8'h00);
    chk("t3_wrap_down", cnt, 8'hFF);

    // req1 raised while busy is served only after req0 completes
    model = model + 8'd1;
    sb.push_back('{id: 1'b0, cnt: model});
    req0 = 1'b1; cmd0 = INC;
    step();
    chk("t5_gnt0", gnt0, 1);
    req0 = 1'b0;
    model = model + 8'd1;
    sb.push_back('{id: 1'b1, cnt: model});
    req1 = 1'b1; cmd1 = INC;
    step();
    chk("t5_no_gnt1_exec", gnt1, 0);
    step();
    chk("t5_done0", done, 1);
    chk("t5_no_gnt1_done", gnt1, 0);
    step();
    chk("t5_idle", busy, 0);
    chk("t5_no_gnt1_idle", gnt1, 0);
    step();
    chk("t5_gnt1", gnt1, 1);
    req1 = 1'b0;
    step();
    step();
    chk("t5_done1", done, 1);
    chk("t5_cnt", cnt, 8'h01);
    step();

    // NOP keeps the value but still completes at nominal latency
    issue(1'b0, LOAD, 8'h42);
    issue(1'b0, NOP, 8'h99);
    chk("t6_cnt", cnt, 8'h42);

    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
